// File: rtl/ustc_xbar_pkg.sv
// Shared types for the sparse-operand crossbar route controller.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package ustc_xbar_pkg;

  // Source-index width for an N-port crossbar; never narrower than one bit.
  function automatic int xbar_idxw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Default port count and the matching index width.
  localparam int XBAR_N_DEF    = 8;
  localparam int XBAR_IDXW_DEF = xbar_idxw(XBAR_N_DEF);

  // Route-controller FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_HOLD  = 2'd2
  } xbar_state_e;

  // Route request at the default port count: field j names the source for output j.
  typedef struct packed {
    logic [XBAR_N_DEF-1:0][XBAR_IDXW_DEF-1:0] src;
    logic [XBAR_N_DEF-1:0]                    en;
  } xbar_route_t;

endpackage

// File: rtl/ustc_route_conflict_chk.sv
// Pairwise source-compare and range check of a route request; builds the one-hot ctrl matrix.
// Latency: purely combinational.
// Backpressure: none; the caller decides what to do with a conflict.
module ustc_route_conflict_chk
  import ustc_xbar_pkg::*;
#(
  parameter int N    = XBAR_N_DEF,
  parameter int IDXW = xbar_idxw(N)
) (
  input  logic [N*IDXW-1:0] src_i,
  input  logic [N-1:0]      en_i,
  output logic              conflict_o,
  output logic [N*N-1:0]    ctrl_o
);

  // Walk every enabled output: flag out-of-range or shared sources, set bit src*N+j otherwise.
  always_comb begin
    conflict_o = 1'b0;
    ctrl_o     = '0;
    for (int j = 0; j < N; j++) begin
      if (en_i[j]) begin
        // Only reachable when N is not a power of two.
        if (int'(src_i[j*IDXW +: IDXW]) >= N) begin
          conflict_o = 1'b1;
        end
        // A disabled output never conflicts, so both sides must be enabled.
        for (int k = j + 1; k < N; k++) begin
          if (en_i[k] && (src_i[j*IDXW +: IDXW] == src_i[k*IDXW +: IDXW])) begin
            conflict_o = 1'b1;
          end
        end
        // Row i, column j: input i drives output j.
        for (int i = 0; i < N; i++) begin
          if (int'(src_i[j*IDXW +: IDXW]) == i) begin
            ctrl_o[i*N + j] = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/ustc_crossbar_route_ctrl.sv
// Crossbar route controller: accepts one route request, checks it, drives ctrl/hold_in through the switch drain.
// Latency: accept at T -> ctrl/hold_in at T+2, out_valid at T+2+DRAIN, idle again at T+3+DRAIN; conflict -> err at T+2.
// Backpressure: req_ready is low from the cycle after accept until the controller is back in IDLE; no queueing.
module ustc_crossbar_route_ctrl
  import ustc_xbar_pkg::*;
#(
  parameter int N     = XBAR_N_DEF,
  parameter int IDXW  = xbar_idxw(N),
  parameter int DRAIN = 2*N - 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [N*IDXW-1:0] req_src,
  input  logic [N-1:0]      req_en,
  output logic [N*N-1:0]    ctrl,
  output logic              hold_in,
  output logic              out_valid,
  output logic [N-1:0]      out_mask,
  output logic              err_conflict,
  output logic              busy
);

  // Drain counter wide enough to hold DRAIN itself; it parks there rather than wrapping.
  localparam int            CW      = (DRAIN > 0) ? $clog2(DRAIN + 1) : 1;
  localparam logic [CW-1:0] DRAIN_C = CW'(DRAIN);

  xbar_state_e         state_q, state_d;
  logic [N*IDXW-1:0]   src_q, src_d;
  logic [N-1:0]        en_q, en_d;
  logic [N*N-1:0]      ctrl_q, ctrl_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                err_q, err_d;

  logic                accept;
  logic                drain_done;
  logic                chk_conflict;
  logic [N*N-1:0]      chk_ctrl;

  assign accept     = req_valid && req_ready;
  assign drain_done = (cnt_q == DRAIN_C);

  // Checker sees only the registered request, so CHECK is a clean one-cycle stage.
  ustc_route_conflict_chk #(
    .N    (N),
    .IDXW (IDXW)
  ) u_chk (
    .src_i      (src_q),
    .en_i       (en_q),
    .conflict_o (chk_conflict),
    .ctrl_o     (chk_ctrl)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: IDLE -> CHECK on accept, CHECK -> HOLD or back to IDLE, HOLD -> IDLE after drain.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_CHECK;
      ST_CHECK: state_d = chk_conflict ? ST_IDLE : ST_HOLD;
      ST_HOLD:  if (drain_done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs; ready is forced low while reset is asserted.
  always_comb begin
    req_ready    = (state_q == ST_IDLE) && !reset;
    busy         = (state_q != ST_IDLE);
    hold_in      = (state_q == ST_HOLD);
    out_valid    = (state_q == ST_HOLD) && drain_done;
    out_mask     = out_valid ? en_q : '0;
    ctrl         = ctrl_q;
    err_conflict = err_q;
  end

  // Datapath next-state: capture request, load or reject ctrl, run the drain counter.
  always_comb begin
    src_d  = src_q;
    en_d   = en_q;
    ctrl_d = ctrl_q;
    cnt_d  = cnt_q;
    err_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          src_d = req_src;
          en_d  = req_en;
        end
      end
      ST_CHECK: begin
        cnt_d = '0;
        if (chk_conflict) begin
          err_d  = 1'b1;
          ctrl_d = '0;
        end else begin
          ctrl_d = chk_ctrl;
        end
      end
      ST_HOLD: begin
        // ctrl stays frozen for the whole drain and drops on the edge that leaves HOLD.
        if (drain_done) begin
          ctrl_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        ctrl_d = '0;
      end
    endcase
  end

  // Datapath registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      src_q  <= '0;
      en_q   <= '0;
      ctrl_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      src_q  <= src_d;
      en_q   <= en_d;
      ctrl_q <= ctrl_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

endmodule

// File: tb/tb_ustc_crossbar_route_ctrl.sv
// Directed bench for ustc_crossbar_route_ctrl at N=4, DRAIN=7.
// Latency: accept at T -> ctrl at T+2, out_valid at T+9, idle at T+10.
// Backpressure: exercised with req_valid held high continuously.
module tb_ustc_crossbar_route_ctrl;

  localparam int N     = 4;
  localparam int IDXW  = 2;
  localparam int DRAIN = 7;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic [N*IDXW-1:0] req_src;
  logic [N-1:0]      req_en;
  logic [N*N-1:0]    ctrl;
  logic              hold_in;
  logic              out_valid;
  logic [N-1:0]      out_mask;
  logic              err_conflict;
  logic              busy;

  int total = 0;
  int bad   = 0;

  ustc_crossbar_route_ctrl #(.N(N), .IDXW(IDXW), .DRAIN(DRAIN)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_src      (req_src),
    .req_en       (req_en),
    .ctrl         (ctrl),
    .hold_in      (hold_in),
    .out_valid    (out_valid),
    .out_mask     (out_mask),
    .err_conflict (err_conflict),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Advance one cycle and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a request once ready is seen (bounded); returns in cycle T+1 of the accept edge T.
  task automatic accept(input logic [7:0] src, input logic [3:0] en);
    int w = 0;
    while (req_ready !== 1'b1 && w < 50) begin
      step();
      w++;
    end
    if (w >= 50) begin
      total++; bad++;
      $display("FAIL accept_wait: req_ready=%b after %0d cycles, want 1", req_ready, w);
    end
    req_src   = src;
    req_en    = en;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  // Run one full request and record what the DUT showed at key cycles (offsets from accept edge T).
  task automatic run_req(input logic [7:0] src, input logic [3:0] en,
                         output logic [15:0] c2, output logic h2, output int ovc,
                         output logic [3:0] mov, output logic [15:0] cov,
                         output logic [15:0] caft, output logic haft, output logic raft,
                         output logic chg);
    accept(src, en);
    step();
    c2  = ctrl;
    h2  = hold_in;
    ovc = -1;
    mov = '0;
    cov = '0;
    chg = 1'b0;
    for (int c = 2; c <= 20 && ovc < 0; c++) begin
      if (c > 2) step();
      if (hold_in === 1'b1 && ctrl !== c2) chg = 1'b1;
      if (out_valid === 1'b1) begin
        ovc = c;
        mov = out_mask;
        cov = ctrl;
      end
    end
    step();
    caft = ctrl;
    haft = hold_in;
    raft = req_ready;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_src = '0; req_en = '0;
    repeat (3) step();
    total++; if (ctrl !== 16'h0 || hold_in !== 1'b0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL rst_outs: ctrl=%h hold=%b ov=%b want 0/0/0", ctrl, hold_in, out_valid); end
    total++; if (out_mask !== 4'h0 || err_conflict !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL rst_status: mask=%h err=%b busy=%b want 0/0/0", out_mask, err_conflict, busy); end
    total++; if (req_ready !== 1'b0) begin
      bad++; $display("FAIL rst_ready_in_reset: got %b want 0", req_ready); end
    reset = 1'b0;
    #1;
    total++; if (req_ready !== 1'b1) begin
      bad++; $display("FAIL rst_ready_after: got %b want 1", req_ready); end
  endtask

  task automatic test_identity();
    logic [15:0] c2, cov, caft; logic h2, haft, raft, chg; int ovc; logic [3:0] mov;
    accept(8'hE4, 4'hF);
    total++; if (busy !== 1'b1 || req_ready !== 1'b0 || hold_in !== 1'b0) begin
      bad++; $display("FAIL id_check_cycle: busy=%b rdy=%b hold=%b want 1/0/0", busy, req_ready, hold_in); end
    // Finish this request by polling, then repeat it through run_req for the timing checks.
    while (busy === 1'b1) step();
    run_req(8'hE4, 4'hF, c2, h2, ovc, mov, cov, caft, haft, raft, chg);
    total++; if (c2 !== 16'h8421 || h2 !== 1'b1) begin
      bad++; $display("FAIL id_ctrl_t2: ctrl=%h hold=%b want 8421/1", c2, h2); end
    total++; if (ovc !== 2 + DRAIN) begin
      bad++; $display("FAIL id_ov_cycle: got T+%0d want T+%0d", ovc, 2 + DRAIN); end
    total++; if (mov !== 4'hF || cov !== 16'h8421) begin
      bad++; $display("FAIL id_ov_data: mask=%h ctrl=%h want F/8421", mov, cov); end
    total++; if (chg !== 1'b0) begin
      bad++; $display("FAIL id_ctrl_stable: ctrl changed while hold_in high"); end
    total++; if (caft !== 16'h0 || haft !== 1'b0 || raft !== 1'b1) begin
      bad++; $display("FAIL id_after: ctrl=%h hold=%b rdy=%b want 0/0/1", caft, haft, raft); end
  endtask

  task automatic test_permutation();
    logic [15:0] c2, cov, caft; logic h2, haft, raft, chg; int ovc; logic [3:0] mov;
    logic [7:0] din [4];
    int         perm [4];
    logic [7:0] o;
    din  = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
    perm = '{2, 0, 3, 1};
    run_req(8'h72, 4'hF, c2, h2, ovc, mov, cov, caft, haft, raft, chg);
    total++; if (c2 !== 16'h4182) begin
      bad++; $display("FAIL perm_ctrl: got %h want 4182", c2); end
    total++; if (ovc !== 2 + DRAIN || mov !== 4'hF) begin
      bad++; $display("FAIL perm_ov: cycle=T+%0d mask=%h want T+%0d/F", ovc, mov, 2 + DRAIN); end
    for (int j = 0; j < N; j++) begin
      o = '0;
      for (int i = 0; i < N; i++) if (cov[i*N + j]) o = o | din[i];
      total++; if (o !== din[perm[j]]) begin
        bad++; $display("FAIL perm_xbar_out%0d: got %h want %h", j, o, din[perm[j]]); end
    end
  endtask

  task automatic test_conflict();
    logic any_bad;
    accept(8'hD1, 4'hF);
    total++; if (err_conflict !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL cf_t1: err=%b busy=%b want 0/1", err_conflict, busy); end
    step();
    total++; if (err_conflict !== 1'b1 || req_ready !== 1'b1) begin
      bad++; $display("FAIL cf_t2: err=%b rdy=%b want 1/1", err_conflict, req_ready); end
    total++; if (ctrl !== 16'h0 || hold_in !== 1'b0) begin
      bad++; $display("FAIL cf_t2_ctrl: ctrl=%h hold=%b want 0/0", ctrl, hold_in); end
    step();
    total++; if (err_conflict !== 1'b0) begin
      bad++; $display("FAIL cf_pulse_width: err=%b at T+3 want 0", err_conflict); end
    any_bad = 1'b0;
    repeat (10) begin
      if (out_valid !== 1'b0 || hold_in !== 1'b0 || ctrl !== 16'h0) any_bad = 1'b1;
      step();
    end
    total++; if (any_bad !== 1'b0) begin
      bad++; $display("FAIL cf_quiet: activity=%b after rejected request want 0", any_bad); end
  endtask

  task automatic test_partial_enable();
    logic [15:0] c2, cov, caft; logic h2, haft, raft, chg; int ovc; logic [3:0] mov;
    logic saw_err;
    saw_err = 1'b0;
    fork
      begin
        run_req(8'hCE, 4'b0101, c2, h2, ovc, mov, cov, caft, haft, raft, chg);
      end
      begin
        repeat (14) begin
          @(negedge clk);
          if (err_conflict === 1'b1) saw_err = 1'b1;
        end
      end
    join
    total++; if (saw_err !== 1'b0) begin
      bad++; $display("FAIL pe_err: err_conflict seen=%b want 0", saw_err); end
    total++; if (c2 !== 16'h0104) begin
      bad++; $display("FAIL pe_ctrl: got %h want 0104", c2); end
    total++; if (ovc !== 2 + DRAIN || mov !== 4'b0101) begin
      bad++; $display("FAIL pe_ov: cycle=T+%0d mask=%b want T+%0d/0101", ovc, mov, 2 + DRAIN); end
  endtask

  task automatic test_zero_enable();
    logic [15:0] c2, cov, caft; logic h2, haft, raft, chg; int ovc; logic [3:0] mov;
    run_req(8'hE4, 4'h0, c2, h2, ovc, mov, cov, caft, haft, raft, chg);
    total++; if (c2 !== 16'h0 || h2 !== 1'b1) begin
      bad++; $display("FAIL ze_t2: ctrl=%h hold=%b want 0/1", c2, h2); end
    total++; if (ovc !== 2 + DRAIN || mov !== 4'h0) begin
      bad++; $display("FAIL ze_ov: cycle=T+%0d mask=%h want T+%0d/0", ovc, mov, 2 + DRAIN); end
    total++; if (raft !== 1'b1 || haft !== 1'b0) begin
      bad++; $display("FAIL ze_after: rdy=%b hold=%b want 1/0", raft, haft); end
  endtask

  task automatic test_backpressure();
    int acc [$];
    logic rdy_busy;
    rdy_busy = 1'b0;
    req_src   = 8'hE4;
    req_en    = 4'hF;
    req_valid = 1'b1;
    for (int c = 0; c < 35; c++) begin
      if (req_ready === 1'b1) acc.push_back(c);
      if (busy === 1'b1 && req_ready !== 1'b0) rdy_busy = 1'b1;
      step();
    end
    req_valid = 1'b0;
    repeat (12) step();
    total++; if (acc.size() !== 4) begin
      bad++; $display("FAIL bp_count: accepts=%0d want 4", acc.size()); end
    for (int k = 1; k < acc.size(); k++) begin
      total++; if (acc[k] - acc[k-1] !== DRAIN + 3) begin
        bad++; $display("FAIL bp_spacing%0d: got %0d want %0d", k, acc[k] - acc[k-1], DRAIN + 3); end
    end
    total++; if (rdy_busy !== 1'b0) begin
      bad++; $display("FAIL bp_ready_busy: ready high while busy=%b want 0", rdy_busy); end
  endtask

  task automatic test_reset_mid_hold();
    logic saw_ov;
    accept(8'hE4, 4'hF);
    repeat (4) step();
    total++; if (hold_in !== 1'b1) begin
      bad++; $display("FAIL rh_pre: hold=%b at T+5 want 1", hold_in); end
    reset = 1'b1;
    step();
    total++; if (ctrl !== 16'h0 || hold_in !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b0) begin
      bad++; $display("FAIL rh_clear: ctrl=%h hold=%b busy=%b rdy=%b want 0/0/0/0", ctrl, hold_in, busy, req_ready); end
    total++; if (out_valid !== 1'b0 || out_mask !== 4'h0 || err_conflict !== 1'b0) begin
      bad++; $display("FAIL rh_status: ov=%b mask=%h err=%b want 0/0/0", out_valid, out_mask, err_conflict); end
    reset = 1'b0;
    #1;
    total++; if (req_ready !== 1'b1) begin
      bad++; $display("FAIL rh_ready: got %b want 1", req_ready); end
    saw_ov = 1'b0;
    repeat (12) begin
      step();
      if (out_valid === 1'b1) saw_ov = 1'b1;
    end
    total++; if (saw_ov !== 1'b0) begin
      bad++; $display("FAIL rh_no_ov: out_valid seen=%b want 0", saw_ov); end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_permutation();
    test_conflict();
    test_partial_enable();
    test_zero_enable();
    test_backpressure();
    test_reset_mid_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ustc_crossbar_route_ctrl.md
# ustc_crossbar_route_ctrl

Generates the N×N one-hot switch-control matrix for the sparse-operand crossbar from a per-output route request. It validates that no input is routed to more than one output. It holds the matrix stable for the full switch-pipeline drain and tells the data source when to hold its lines and when crossbar outputs are valid. It sits between the sparse-metadata decoder, which issues route requests, and the crossbar, which consumes `ctrl`.

## Interface
Parameters:
- `N`, 8: crossbar ports (inputs = outputs).
- `IDXW`, `$clog2(N)`: source-index width, from the shared package.
- `DRAIN`, `2*N-1`: cycles from the first hold cycle to outputs valid, equal to the worst-case switch path.

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high.
  - `clk`  in  1  clock.
  - `reset`  in  1  synchronous reset.
- Request side:
  - `req_valid`  in  1  a route request is offered.
  - `req_ready`  out  1  request can be accepted.
  - `req_src`  in  N*IDXW  field j is the source input index for output j.
  - `req_en`  in  N  bit j enables output j.
- Crossbar side:
  - `ctrl`  out  N*N  bit i*N+j set means input i drives output j; registered.
- Data-source side:
  - `hold_in`  out  1  the data source must hold the crossbar `in` bus stable while high.
- Status:
  - `out_valid`  out  1  one-cycle pulse; crossbar `out` is valid this cycle.
  - `out_mask`  out  N  valid with `out_valid`; copy of the accepted `req_en`.
  - `err_conflict`  out  1  one-cycle pulse; the request was rejected.
  - `busy`  out  1  state is not IDLE.

## Operation
- FSM states: IDLE, CHECK, HOLD.
- IDLE:
  - `req_ready` is high (and low whenever `reset` is high).
  - On `req_valid && req_ready`, register `req_src`/`req_en` and go to CHECK.
- CHECK (one cycle):
  - A conflict exists if two enabled outputs name the same source, or if an enabled index is ≥ N.
  - On conflict: pulse `err_conflict` next cycle, leave `ctrl` at 0, return to IDLE.
  - Otherwise: load `ctrl` (bit `src[j]*N+j` for each enabled j), clear the drain counter, go to HOLD.
- HOLD:
  - `ctrl` is held constant and `hold_in` = 1.
  - The counter increments each cycle.
  - When the counter reaches `DRAIN`, pulse `out_valid` with `out_mask` in that same cycle.
  - On the following cycle, `ctrl` ← 0, `hold_in` ← 0, return to IDLE.
- `req_en` = 0 (all outputs disabled) is legal:
  - No conflict; `ctrl` stays 0.
  - HOLD still runs for the full drain; `out_valid` pulses with `out_mask` = 0.
- One request is in flight at a time; there is no queueing.

## Timing
- Reset values: `ctrl` 0, `hold_in` 0, `out_valid` 0, `out_mask` 0, `err_conflict` 0, `busy` 0, state IDLE, counter 0.
- Reset asserted mid-HOLD clears everything on that edge. `req_ready` is high the first cycle after `reset` drops.
- Accept at edge T:
  - `busy` = 1 from T+1.
  - `ctrl` and `hold_in` valid from T+2.
  - `out_valid` at T+2+`DRAIN`.
  - `ctrl` = 0 and `req_ready` = 1 at T+3+`DRAIN`.
- Back-to-back requests: the minimum request-to-request spacing is `DRAIN`+3 cycles.
- Conflict at accept edge T: `err_conflict` at T+2, `req_ready` high at T+2.
- Path latency from input i to output j is j+N−i switch stages. `DRAIN` covers the maximum (i=0, j=N−1).
- Counter width: `$clog2(DRAIN+1)`; it saturates at `DRAIN`, with no wrap.
- `ctrl` never changes while `hold_in` = 1.

## Structure
- Shared package `ustc_xbar_pkg` holds:
  - `IDXW` derivation;
  - FSM state enum;
  - `xbar_route_t` (packed src array plus en vector).
- Natural sub-module `ustc_route_conflict_chk`: combinational pairwise source compare and range check over the registered request, producing `conflict` and the one-hot `ctrl` matrix.
- Top level holds the FSM, request registers, drain counter and output registers.

## Test plan
Scenarios use N=4, DRAIN=7.
- Identity route: `req_src`={3,2,1,0} (output3..0), `req_en`=4'hF, accept at T → at T+2, `ctrl` = 16'h8421 and `hold_in`=1; `out_valid` at T+9 with `out_mask`=4'hF; `ctrl`=0 at T+10.
- Permutation: output0←2, output1←0, output2←3, output3←1, all enabled → `ctrl` bits 8, 1, 14 and 7 set (16'h4182); bench crossbar output j equals input `src[j]` at the `out_valid` cycle.
- Conflict: outputs 0 and 2 both ←1, both enabled → `err_conflict` pulse at T+2; `ctrl`, `hold_in` and `out_valid` stay 0; `req_ready`=1 at T+2.
- Partial enable: `req_en`=4'b0101, outputs 1 and 3 name the same source (disabled, so not a conflict) → no error; only two `ctrl` bits set; `out_mask`=4'b0101.
- Backpressure: hold `req_valid`=1 continuously → a new accept only every 10 cycles; `req_ready`=0 throughout CHECK and HOLD.
- Reset at T+5 mid-HOLD → next cycle all outputs are at reset values and no `out_valid`; `req_ready`=1 the cycle after `reset` falls.
